// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory access path.
//   - Size encodings of the load/store request.
//   - State encoding of the access sequencer.
//   - Access-error check (reserved size or misaligned sub-word/word).
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW_RD,
    ST_GAP,
    ST_WR,
    ST_RESP
  } mau_state_t;

  // An erroneous request never touches memory: reserved size, a halfword on
  // an odd byte, or a word that is not on a 4-byte boundary.
  function automatic logic access_err(input logic [1:0] size,
                                      input logic [1:0] offset);
    logic err;
    err = 1'b0;
    case (size)
      SZ_HALF: err = offset[0];
      SZ_WORD: err = (offset != 2'b00);
      SZ_RSVD: err = 1'b1;
      default: err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational big-endian lane handling for a word-wide memory.
//   word       : word read from memory
//   offset     : byte offset within the word (0 = bits[31:24])
//   size       : SZ_BYTE / SZ_HALF / SZ_WORD
//   sgn        : sign-extend the extracted sub-word lane
//   wdata      : right-justified store data
//   load_val   : extracted and extended load result
//   store_word : word with the store lane merged in (wdata for word size)
module lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_word;
  logic [31:0] half_word;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Big-endian: offset 0 is the most significant lane, so the right-shift
  // amount is (3 - offset) bytes, i.e. the inverted offset.
  assign byte_sh   = {~offset, 3'b000};
  assign half_sh   = {~offset[1], 4'b0000};
  assign byte_word = word >> byte_sh;
  assign half_word = word >> half_sh;
  assign byte_lane = byte_word[7:0];
  assign half_lane = half_word[15:0];

  always_comb begin
    load_val   = word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_val   = {{24{sgn & byte_lane[7]}}, byte_lane};
        store_word = (word & ~(32'h0000_00FF << byte_sh))
                   | ({24'd0, wdata[7:0]} << byte_sh);
      end
      SZ_HALF: begin
        load_val   = {{16{sgn & half_lane[15]}}, half_lane};
        store_word = (word & ~(32'h0000_FFFF << half_sh))
                   | ({16'd0, wdata[15:0]} << half_sh);
      end
      default: begin
        load_val   = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of a word-only data memory for the MEM pipeline stage.
// Takes one load/store at a time, sequences memRead/memWrite, extracts and
// extends sub-word loads and does read-modify-write for sub-word stores.
//   clk, reset                : clock, async active-high reset
//   req_valid/req_ready       : request handshake (ready only when idle)
//   req_write/size/signed     : access kind
//   req_addr/req_wdata        : byte address, right-justified store data
//   resp_valid/rdata/err      : single-cycle completion
//   memRead/memWrite          : memory strobes (never both high)
//   mem_address/writedata     : word-aligned address, store word
//   mem_readdata              : word returned by memory
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  mau_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              err_q, err_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       wr_word_q, wr_word_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic [31:0] la_load;
  logic [31:0] la_store;
  logic        req_err;

  // Lane handling works directly on the memory bus so the load result and
  // the merged store word are ready in the last read cycle.
  lane_align u_lane_align (
    .word       (mem_readdata),
    .offset     (addr_q[1:0]),
    .size       (size_q),
    .sgn        (sgn_q),
    .wdata      (wdata_q),
    .load_val   (la_load),
    .store_word (la_store)
  );

  assign req_err = access_err(req_size, req_addr[1:0]);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    err_d        = err_q;
    wdata_d      = wdata_q;
    wr_word_d    = wr_word_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          sgn_d   = req_signed;
          wdata_d = req_wdata;
          err_d   = req_err;
          cnt_d   = '0;
          if (req_err) begin
            resp_rdata_d = 32'd0;
            state_d      = ST_RESP;
          end else if (!req_write) begin
            state_d = ST_RD;
          end else if (req_size == SZ_WORD) begin
            wr_word_d = req_wdata;
            state_d   = ST_WR;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q == CNT_LAST) begin
          resp_rdata_d = la_load;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RMW_RD: begin
        if (cnt_q == CNT_LAST) begin
          wr_word_d = la_store;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Memory reacts to strobe edges, so the write is separated from the
      // read of the same word by one idle cycle.
      ST_GAP: state_d = ST_WR;
      ST_WR: begin
        resp_rdata_d = 32'd0;
        state_d      = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      size_q       <= SZ_WORD;
      sgn_q        <= 1'b0;
      err_q        <= 1'b0;
      wdata_q      <= 32'd0;
      wr_word_q    <= 32'd0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      err_q        <= err_d;
      wdata_q      <= wdata_d;
      wr_word_q    <= wr_word_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Strobes decode straight from the state register so an async reset
  // drops them in the same cycle and an unfinished RMW never writes.
  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_err      = (state_q == ST_RESP) && err_q;
  assign resp_rdata    = resp_rdata_q;
  assign memRead       = (state_q == ST_RD) || (state_q == ST_RMW_RD);
  assign memWrite      = (state_q == ST_WR);
  assign mem_address   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_writedata = wr_word_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic        rdy_a, rv_a, er_a, mr_a, mw_a;
  logic [31:0] rd_a, ma_a, mwd_a, mrd_a;
  logic        rdy_b, rv_b, er_b, mr_b, mw_b;
  logic [31:0] rd_b, ma_b, mwd_b, mrd_b;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] ref_mem [2][64];

  int n_tests = 0;
  int n_fail  = 0;
  int rdc_a = 0, wrc_a = 0, rdc_b = 0, wrc_b = 0;
  logic cur = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.READ_LAT(1), .ADDR_W(32)) dut_a (
    .clk(clk), .reset(reset), .req_valid(valid_a), .req_ready(rdy_a),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_a),
    .resp_rdata(rd_a), .resp_err(er_a), .memRead(mr_a), .memWrite(mw_a),
    .mem_address(ma_a), .mem_writedata(mwd_a), .mem_readdata(mrd_a));

  mem_access_unit #(.READ_LAT(3), .ADDR_W(32)) dut_b (
    .clk(clk), .reset(reset), .req_valid(valid_b), .req_ready(rdy_b),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv_b),
    .resp_rdata(rd_b), .resp_err(er_b), .memRead(mr_b), .memWrite(mw_b),
    .mem_address(ma_b), .mem_writedata(mwd_b), .mem_readdata(mrd_b));

  // Word memories: combinational read, write on the clock edge.
  assign mrd_a = mem_a[ma_a[7:2]];
  assign mrd_b = mem_b[ma_b[7:2]];
  always @(posedge clk) begin
    if (mw_a) mem_a[ma_a[7:2]] <= mwd_a;
    if (mw_b) mem_b[ma_b[7:2]] <= mwd_b;
    rdc_a <= rdc_a + (mr_a ? 1 : 0);
    wrc_a <= wrc_a + (mw_a ? 1 : 0);
    rdc_b <= rdc_b + (mr_b ? 1 : 0);
    wrc_b <= wrc_b + (mw_b ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe protocol watch on both units.
  logic        pmr_a = 0, pmw_a = 0, pmr_b = 0, pmw_b = 0;
  logic [31:0] pma_a = 0, pmwd_a = 0, pma_b = 0, pmwd_b = 0;
  always @(negedge clk) begin
    if (mr_a || mw_a) begin
      chk("excl_a", 32'(mr_a & mw_a), 32'd0);
      chk("bracket_a", 32'((pmr_a & mw_a) | (pmw_a & mr_a)), 32'd0);
      if (pmr_a || pmw_a) chk("addr_stable_a", ma_a, pma_a);
      if (mw_a && pmw_a) chk("wdata_stable_a", mwd_a, pmwd_a);
    end
    if (mr_b || mw_b) begin
      chk("excl_b", 32'(mr_b & mw_b), 32'd0);
      chk("bracket_b", 32'((pmr_b & mw_b) | (pmw_b & mr_b)), 32'd0);
      if (pmr_b || pmw_b) chk("addr_stable_b", ma_b, pma_b);
      if (mw_b && pmw_b) chk("wdata_stable_b", mwd_b, pmwd_b);
    end
    pmr_a = mr_a; pmw_a = mw_a; pma_a = ma_a; pmwd_a = mwd_a;
    pmr_b = mr_b; pmw_b = mw_b; pma_b = ma_b; pmwd_b = mwd_b;
  end

  // Reference: memory as an array of words, access rules in plain arithmetic.
  function automatic void model(input logic [31:0] w, input logic wr,
                                input logic [1:0] sz, input logic sg,
                                input logic [7:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err,
                                output logic [31:0] neww);
    int sh;
    err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    rd   = 32'd0;
    neww = w;
    if (err) return;
    if (sz == 2'd0) begin
      sh = (3 - int'(a[1:0])) * 8;
      if (wr) neww = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      else begin
        rd = (w >> sh) & 32'hFF;
        if (sg && rd[7]) rd = rd | 32'hFFFF_FF00;
      end
    end else if (sz == 2'd1) begin
      sh = (2 - int'(a[1:0])) * 8;
      if (wr) neww = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      else begin
        rd = (w >> sh) & 32'hFFFF;
        if (sg && rd[15]) rd = rd | 32'hFFFF_0000;
      end
    end else begin
      if (wr) neww = wd;
      else rd = w;
    end
  endfunction

  task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [7:0] a, input logic [31:0] wd,
                     output logic [31:0] got);
    int idx, rl, elat, erdc, ewrc, lat, k, rc0, wc0;
    logic [31:0] erd, nw;
    logic eerr;
    idx = int'(a[7:2]);
    rl  = cur ? 3 : 1;
    model(ref_mem[cur][idx], w, sz, sg, a, wd, erd, eerr, nw);
    elat = eerr ? 1 : (!w ? rl + 1 : (sz == 2'd2 ? 2 : rl + 3));
    erdc = (eerr || (w && sz == 2'd2)) ? 0 : rl;
    ewrc = (!eerr && w) ? 1 : 0;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg;
    req_addr = {24'd0, a}; req_wdata = wd;
    if (cur) valid_b = 1'b1; else valid_a = 1'b1;
    k = 0;
    while (!(cur ? rdy_b : rdy_a) && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("ready_timeout", 32'd0, 32'd1);
    rc0 = cur ? rdc_b : rdc_a;
    wc0 = cur ? wrc_b : wrc_a;
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
    lat = 1;
    while (!(cur ? rv_b : rv_a) && lat < 50) begin @(negedge clk); lat++; end
    got = cur ? rd_b : rd_a;
    chk("latency", 32'(lat), 32'(elat));
    chk("rdata", got, erd);
    chk("err", 32'(cur ? er_b : er_a), 32'(eerr));
    chk("rd_cycles", 32'((cur ? rdc_b : rdc_a) - rc0), 32'(erdc));
    chk("wr_cycles", 32'((cur ? wrc_b : wrc_a) - wc0), 32'(ewrc));
    if (w && !eerr) ref_mem[cur][idx] = nw;
  endtask

  initial begin
    logic [31:0] got;
    int a1, a2, r1, acc, resp, run, wc0;
    int runs[$];
    bit chg;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    chk("rst_resp_valid", 32'(rv_a), 32'd0);
    chk("rst_rdata", rd_a, 32'd0);
    chk("rst_err", 32'(er_a), 32'd0);
    chk("rst_strobes", 32'({mr_a, mw_a}), 32'd0);
    chk("rst_addr", ma_a, 32'd0);
    chk("rst_wdata", mwd_a, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fill both memories with known words
    for (int u = 0; u < 2; u++) begin
      cur = u[0];
      for (int i = 0; i < 64; i++) txn(1'b1, 2'd2, 1'b0, 8'(i * 4), $urandom, got);
    end
    cur = 1'b0;

    // Word store then load
    txn(1'b1, 2'd2, 1'b0, 8'h40, 32'hDEADBEEF, got);
    txn(1'b0, 2'd2, 1'b0, 8'h40, 32'd0, got);
    chk("lw_deadbeef", got, 32'hDEADBEEF);

    // Sub-word loads
    txn(1'b1, 2'd2, 1'b0, 8'h40, 32'h80FF7F01, got);
    txn(1'b0, 2'd0, 1'b1, 8'h40, 32'd0, got); chk("lb_s", got, 32'hFFFFFF80);
    txn(1'b0, 2'd0, 1'b0, 8'h43, 32'd0, got); chk("lbu", got, 32'h00000001);
    txn(1'b0, 2'd1, 1'b1, 8'h42, 32'd0, got); chk("lh_s", got, 32'h00007F01);
    txn(1'b0, 2'd1, 1'b0, 8'h40, 32'd0, got); chk("lhu", got, 32'h000080FF);

    // Sub-word store RMW
    txn(1'b1, 2'd2, 1'b0, 8'h40, 32'h11223344, got);
    txn(1'b1, 2'd0, 1'b0, 8'h41, 32'h000000AA, got);
    txn(1'b0, 2'd2, 1'b0, 8'h40, 32'd0, got); chk("sb_merge", got, 32'h11AA3344);

    // Errors
    txn(1'b0, 2'd2, 1'b0, 8'h42, 32'd0, got);
    txn(1'b1, 2'd1, 1'b0, 8'h45, 32'h1234, got);
    txn(1'b0, 2'd3, 1'b0, 8'h40, 32'd0, got);

    // Reset during the GAP of an RMW
    txn(1'b1, 2'd2, 1'b0, 8'h40, 32'h11223344, got);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h41; req_wdata = 32'hAA; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    chk("rmw_read_phase", 32'(mr_a), 32'd1);
    @(negedge clk);
    chk("rmw_gap_low", 32'({mr_a, mw_a}), 32'd0);
    wc0 = wrc_a;
    reset = 1'b1;
    #1;
    chk("rst_mid_strobes", 32'({mr_a, mw_a}), 32'd0);
    chk("rst_mid_ready", 32'(rdy_a), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_mid_no_resp", 32'(rv_a), 32'd0);
      @(negedge clk);
    end
    chk("rst_mid_no_write", 32'(wrc_a - wc0), 32'd0);
    chk("rst_mid_ready_after", 32'(rdy_a), 32'd1);
    txn(1'b0, 2'd2, 1'b0, 8'h40, 32'd0, got); chk("rst_mid_mem", got, 32'h11223344);

    // Random traffic on both latencies
    for (int i = 0; i < 240; i++) begin
      cur = (i >= 160);
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)), $urandom, got);
    end

    // Back-to-back loads on the READ_LAT=3 unit, valid held by the requester
    cur = 1'b1;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h40; valid_b = 1'b1;
    acc = 0; resp = 0; run = 0; a1 = -1; a2 = -1; r1 = -1;
    for (int c = 0; c < 60 && resp < 2; c++) begin
      chg = 1'b0;
      if (mr_b) run++;
      else if (run != 0) begin runs.push_back(run); run = 0; end
      if (rv_b) begin
        resp++;
        if (resp == 1) begin r1 = c; chk("b2b_rdata1", rd_b, ref_mem[1][16]); end
        else chk("b2b_rdata2", rd_b, ref_mem[1][17]);
      end
      if (valid_b && rdy_b) begin
        acc++; chg = 1'b1;
        if (acc == 1) a1 = c; else a2 = c;
      end
      @(negedge clk);
      if (chg && acc == 1) req_addr = 32'h44;
      if (chg && acc == 2) valid_b = 1'b0;
    end
    valid_b = 1'b0;
    if (run != 0) runs.push_back(run);
    chk("b2b_accepts", 32'(acc), 32'd2);
    chk("b2b_resps", 32'(resp), 32'd2);
    chk("b2b_first_lat", 32'(r1 - a1), 32'd4);
    chk("b2b_second_accept", 32'(a2), 32'(r1 + 1));
    chk("b2b_read_windows", 32'(runs.size()), 32'd2);
    foreach (runs[i]) chk("b2b_read_len", 32'(runs[i]), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
